img_edge_pipe: RTL
==================

# img_edge_pipe

Parametrised successor to the camera-path image processor. Takes a raster greyscale pixel stream with a valid strobe and builds a 3x3 window from two internal line buffers. Applies a runtime-selected kernel (passthrough, Sobel Gx, Sobel Gy, or |Gx|+|Gy| magnitude) and emits a saturated result with output coordinates. Sits between the greyscale converter and the RGB output mux.

## Interface
- DATA_W, 12: pixel width, input and output
- LINE_W, 640: pixels per line
- FRAME_H, 480: lines per frame
- iCLK  in  1  clock; all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- iDATA  in  DATA_W  greyscale pixel, unsigned
- iDVAL  in  1  iDATA valid this cycle
- iSOF  in  1  qualified by iDVAL; marks pixel (0,0) of a frame
- iMODE  in  2  00 pass centre, 01 Gx, 10 Gy, 11 |Gx|+|Gy|
- oDATA  out  DATA_W  result pixel
- oDVAL  out  1  oDATA/oX/oY valid
- oX  out  11  output centre column
- oY  out  11  output centre row

## Operation
- Counters x (0..LINE_W-1) and y (0..FRAME_H-1) advance only on iDVAL.
  - x wraps to 0 and increments y. y wraps to 0 after the last line.
  - iDVAL&&iSOF forces the accepted pixel to (0,0), including mid-frame resync.
- Line buffers: a LINE_W-deep, two-tap shift structure, clock-enabled by iDVAL only.
- Window: a 3x3 register array that shifts left on each iDVAL.
  - Its column entry is {tap1, tap0, iDATA}, top to bottom.
  - Accepted pixel (x,y) centres the window on (cx,cy)=(x-1,y-1).
- Emission: a result is produced only when x≥1 and y≥1.
  - Per frame that gives (LINE_W-1)*(FRAME_H-1) outputs.
  - Column LINE_W-1 and row FRAME_H-1 are never emitted as centres.
- Border: cx==0 or cy==0 gives oDATA=0 in every mode except 00.
  - Mode 00 always passes the centre pixel.
- Kernels:
  - Gx = [-1 0 1; -2 0 2; -1 0 1]
  - Gy = [-1 -2 -1; 0 0 0; 1 2 1]
- Arithmetic:
  - Gradients are signed, DATA_W+4 bits. Abs is taken before summing.
  - Magnitude is computed at DATA_W+4 bits.
  - The final result saturates to 2^DATA_W-1.
- Mode latch: iMODE is sampled when iDVAL&&iSOF is accepted, and held for the whole frame.
  - Changes mid-frame are ignored.
  - After reset the latched mode is 00 until the first SOF.
- Reset: clears counters, window, pipeline valids, latched mode, and all outputs.
  - Line-buffer contents are not cleared. The border rule masks stale data in the first row.

## Timing
- Reset values:
  - oDATA=0, oDVAL=0, oX=0, oY=0
  - Window, counters and mode are 0
- Latency: 3 cycles from the accepted pixel to oDVAL.
  - Cycle 1: window register update
  - Cycle 2: kernel sums
  - Cycle 3: abs/sum/saturate, registered into the outputs
- Pipeline advances every cycle; iDVAL bubbles propagate as oDVAL=0.
- oDVAL is 1 for exactly one cycle per emitted centre. There is no backpressure.
- iRST asserted mid-frame: oDVAL is 0 on the next edge, and in-flight results are discarded.
- iSOF coinciding with a counter wrap: iSOF wins, so the pixel is (0,0).

## Configuration
- IMG_EDGE_THRESH_EN defined:
  - Adds input iTHRESH [DATA_W-1:0].
  - In modes 01/10/11, the saturated result ≥ iTHRESH gives all-ones, otherwise 0.
  - iTHRESH is latched alongside iMODE at SOF.
  - Latency is unchanged.
- Not defined: the port is absent and the output is the saturated value.

## Structure
- Package img_edge_pkg holds:
  - the mode enum (MODE_PASS, MODE_GX, MODE_GY, MODE_MAG)
  - Sobel coefficient constants
  - the gradient width localparam
  - a saturate function
- One sub-module, img_line_buf: parametrised on DATA_W and LINE_W, with clken, shiftin, and taps tap0/tap1.

## Test plan
Parameters: DATA_W=12, LINE_W=8, FRAME_H=6.
- Flat field 100, mode 11, gapless: 35 outputs with oDATA=0. oX/oY run from (0,0) to (6,4) in raster order, and the first oDVAL comes 3 cycles after pixel (1,1).
- Columns 0-3 = 0 and 4-7 = 1000, mode 01: interior centres cx=3 and cx=4 give 4000, all others 0. The same frame in mode 10 gives all 0.
- Step 0→4095 across columns, mode 11: step centres give 4095, saturated. The mode 00 frame reproduces iDATA centres exactly.
- iMODE changed from 00 to 01 at mid-frame pixel 20: the rest of that frame stays in passthrough, and the next frame after SOF is Gx.
- Random iDVAL bubbles (~40%) on test 2's frame: the oDATA/oX/oY sequence is identical to the gapless run.
- iRST pulsed at pixel (3,2), then a new SOF: oDVAL is 0 on the following edge. The next frame matches test 2 with row 0 all zero.

Source files
------------

// File: rtl/img_edge_pkg.sv
// Shared types and constants for the img_edge_pipe Sobel filter.
package img_edge_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_GX   = 2'b01,
    MODE_GY   = 2'b10,
    MODE_MAG  = 2'b11
  } mode_e;

  // Gradients carry this many bits beyond the pixel width.
  localparam int unsigned GRAD_EXTRA_W = 4;

  typedef logic signed [2:0] coef_t;

  // Row 0 is the oldest line (top), column 0 the oldest pixel (left).
  localparam coef_t SOBEL_GX [3][3] = '{
    '{-3'sd1, 3'sd0, 3'sd1},
    '{-3'sd2, 3'sd0, 3'sd2},
    '{-3'sd1, 3'sd0, 3'sd1}
  };

  localparam coef_t SOBEL_GY [3][3] = '{
    '{-3'sd1, -3'sd2, -3'sd1},
    '{ 3'sd0,  3'sd0,  3'sd0},
    '{ 3'sd1,  3'sd2,  3'sd1}
  };

  // Clamp a signed value into [0, 2^width-1].
  function automatic int unsigned saturate(input int val, input int unsigned width);
    int max_val;
    max_val = (1 << width) - 1;
    if (val < 0) return 0;
    if (val > max_val) return unsigned'(max_val);
    return unsigned'(val);
  endfunction

endpackage

// File: rtl/img_line_buf.sv
// Two-line delay: tap0 is the pixel one line back, tap1 two lines back.
module img_line_buf #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LINE_W = 640
) (
  input  logic              clk,
  input  logic              clken,
  input  logic [DATA_W-1:0] shiftin,
  output logic [DATA_W-1:0] tap0,
  output logic [DATA_W-1:0] tap1
);

  logic [DATA_W-1:0] sr_q [2*LINE_W];

  // Contents are deliberately not reset; the border rule hides stale lines.
  always_ff @(posedge clk) begin
    if (clken) begin
      sr_q[0] <= shiftin;
      for (int i = 1; i < 2 * LINE_W; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign tap0 = sr_q[LINE_W-1];
  assign tap1 = sr_q[2*LINE_W-1];

endmodule

// File: rtl/img_edge_pipe.sv
// 3x3 passthrough/Sobel filter on a raster pixel stream, 3-cycle latency.
// Build option IMG_EDGE_THRESH_EN adds a per-frame binarisation threshold.
module img_edge_pipe
  import img_edge_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned LINE_W  = 640,
  parameter int unsigned FRAME_H = 480
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
`ifdef IMG_EDGE_THRESH_EN
  input  logic [DATA_W-1:0] iTHRESH,
`endif
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [10:0]       oX,
  output logic [10:0]       oY
);

  localparam int unsigned CW     = 11;
  localparam int unsigned GRAD_W = DATA_W + GRAD_EXTRA_W;
  localparam logic [CW-1:0] X_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(FRAME_H - 1);

  logic [CW-1:0] x_q, y_q, x_d, y_d, px, py;
  mode_e         mode_q, mode_eff;
  logic          emit;
  logic [DATA_W-1:0] tap0, tap1;
  logic [DATA_W-1:0] win_q [3][3];

  logic          v1_q, border1_q, v2_q, border2_q;
  logic [CW-1:0] cx1_q, cy1_q, cx2_q, cy2_q;
  mode_e         mode1_q, mode2_q;
  logic signed [GRAD_W-1:0] gx_d, gy_d, gx2_q, gy2_q, pix_ext;
  logic [DATA_W-1:0] ctr2_q, sat_gx, sat_gy, sat_mag, res;
  logic [GRAD_W-1:0] abs_gx, abs_gy, mag;

`ifdef IMG_EDGE_THRESH_EN
  logic [DATA_W-1:0] thr_q, thr_eff, thr1_q, thr2_q;
  assign thr_eff = iSOF ? iTHRESH : thr_q;
`endif

  img_line_buf #(
    .DATA_W(DATA_W),
    .LINE_W(LINE_W)
  ) u_line_buf (
    .clk    (iCLK),
    .clken  (iDVAL),
    .shiftin(iDATA),
    .tap0   (tap0),
    .tap1   (tap1)
  );

  // SOF overrides the counters, so the accepted pixel is always (0,0) then.
  always_comb begin
    px       = iSOF ? '0 : x_q;
    py       = iSOF ? '0 : y_q;
    mode_eff = iSOF ? mode_e'(iMODE) : mode_q;
    x_d      = x_q;
    y_d      = y_q;
    if (iDVAL) begin
      if (px == X_LAST) begin
        x_d = '0;
        y_d = (py == Y_LAST) ? '0 : py + CW'(1);
      end else begin
        x_d = px + CW'(1);
        y_d = py;
      end
    end
    emit = iDVAL && (px != '0) && (py != '0);
  end

  always_comb begin
    gx_d    = '0;
    gy_d    = '0;
    pix_ext = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pix_ext = $signed({{GRAD_EXTRA_W{1'b0}}, win_q[r][c]});
        gx_d    = gx_d + GRAD_W'(SOBEL_GX[r][c]) * pix_ext;
        gy_d    = gy_d + GRAD_W'(SOBEL_GY[r][c]) * pix_ext;
      end
    end
  end

  // Single-axis modes clamp negative gradients to 0.
  always_comb begin
    abs_gx  = gx2_q[GRAD_W-1] ? -gx2_q : gx2_q;
    abs_gy  = gy2_q[GRAD_W-1] ? -gy2_q : gy2_q;
    mag     = abs_gx + abs_gy;
    sat_gx  = DATA_W'(saturate(int'(gx2_q), DATA_W));
    sat_gy  = DATA_W'(saturate(int'(gy2_q), DATA_W));
    sat_mag = DATA_W'(saturate(int'(mag), DATA_W));
    res     = '0;
    unique case (mode2_q)
      MODE_PASS: res = ctr2_q;
      MODE_GX:   res = sat_gx;
      MODE_GY:   res = sat_gy;
      MODE_MAG:  res = sat_mag;
    endcase
    if (mode2_q != MODE_PASS) begin
      if (border2_q) begin
        res = '0;
      end
`ifdef IMG_EDGE_THRESH_EN
      else begin
        res = (res >= thr2_q) ? '1 : '0;
      end
`endif
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= MODE_PASS;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      v1_q      <= 1'b0;
      border1_q <= 1'b0;
      cx1_q     <= '0;
      cy1_q     <= '0;
      mode1_q   <= MODE_PASS;
      v2_q      <= 1'b0;
      border2_q <= 1'b0;
      cx2_q     <= '0;
      cy2_q     <= '0;
      mode2_q   <= MODE_PASS;
      gx2_q     <= '0;
      gy2_q     <= '0;
      ctr2_q    <= '0;
      oDVAL     <= 1'b0;
      oDATA     <= '0;
      oX        <= '0;
      oY        <= '0;
`ifdef IMG_EDGE_THRESH_EN
      thr_q     <= '0;
      thr1_q    <= '0;
      thr2_q    <= '0;
`endif
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (iDVAL && iSOF) begin
        mode_q <= mode_e'(iMODE);
      end
      if (iDVAL) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= tap1;
        win_q[1][2] <= tap0;
        win_q[2][2] <= iDATA;
      end
      // Mode travels with each pixel so frame boundaries never mix modes.
      v1_q      <= emit;
      cx1_q     <= px - CW'(1);
      cy1_q     <= py - CW'(1);
      border1_q <= (px == CW'(1)) || (py == CW'(1));
      mode1_q   <= mode_eff;
      v2_q      <= v1_q;
      border2_q <= border1_q;
      cx2_q     <= cx1_q;
      cy2_q     <= cy1_q;
      mode2_q   <= mode1_q;
      gx2_q     <= gx_d;
      gy2_q     <= gy_d;
      ctr2_q    <= win_q[1][1];
      oDVAL     <= v2_q;
      if (v2_q) begin
        oDATA <= res;
        oX    <= cx2_q;
        oY    <= cy2_q;
      end
`ifdef IMG_EDGE_THRESH_EN
      if (iDVAL && iSOF) begin
        thr_q <= iTHRESH;
      end
      thr1_q <= thr_eff;
      thr2_q <= thr1_q;
`endif
    end
  end

endmodule
